// File: rtl/id_ex_register_if.sv
// Decode-to-execute bundle: decoded operands and controls in, registered EX-stage copies out.
// The register block takes the slave side; the decode stage and hazard/debug units use master.
interface id_ex_register_if #(
    parameter int LEN         = 32,
    parameter int NB_ADDR     = 5,
    parameter int NB_CTRL_EX  = 4,
    parameter int NB_CTRL_MEM = 3,
    parameter int NB_CTRL_WB  = 2,
    parameter int NB_CNT      = 16
);
    logic                   i_enable;
    logic                   i_stall_flag;
    logic                   i_flush;
    logic [LEN-1:0]         i_pc_next;
    logic [LEN-1:0]         i_read_data_1;
    logic [LEN-1:0]         i_read_data_2;
    logic [LEN-1:0]         i_sign_ext;
    logic [NB_ADDR-1:0]     i_rs;
    logic [NB_ADDR-1:0]     i_rt;
    logic [NB_ADDR-1:0]     i_rd;
    logic [NB_CTRL_EX-1:0]  i_ctrl_ex;
    logic [NB_CTRL_MEM-1:0] i_ctrl_mem;
    logic [NB_CTRL_WB-1:0]  i_ctrl_wb;

    logic [LEN-1:0]         o_pc_next;
    logic [LEN-1:0]         o_read_data_1;
    logic [LEN-1:0]         o_read_data_2;
    logic [LEN-1:0]         o_sign_ext;
    logic [NB_ADDR-1:0]     o_rs;
    logic [NB_ADDR-1:0]     o_rt;
    logic [NB_ADDR-1:0]     o_rd;
    logic [NB_CTRL_EX-1:0]  o_ctrl_ex;
    logic [NB_CTRL_MEM-1:0] o_ctrl_mem;
    logic [NB_CTRL_WB-1:0]  o_ctrl_wb;
    logic                   o_mem_read;
    logic                   o_valid;
    logic [NB_CNT-1:0]      o_bubble_count;

    modport master (
        output i_enable, i_stall_flag, i_flush, i_pc_next, i_read_data_1, i_read_data_2,
               i_sign_ext, i_rs, i_rt, i_rd, i_ctrl_ex, i_ctrl_mem, i_ctrl_wb,
        input  o_pc_next, o_read_data_1, o_read_data_2, o_sign_ext, o_rs, o_rt, o_rd,
               o_ctrl_ex, o_ctrl_mem, o_ctrl_wb, o_mem_read, o_valid, o_bubble_count
    );

    modport slave (
        input  i_enable, i_stall_flag, i_flush, i_pc_next, i_read_data_1, i_read_data_2,
               i_sign_ext, i_rs, i_rt, i_rd, i_ctrl_ex, i_ctrl_mem, i_ctrl_wb,
        output o_pc_next, o_read_data_1, o_read_data_2, o_sign_ext, o_rs, o_rt, o_rd,
               o_ctrl_ex, o_ctrl_mem, o_ctrl_wb, o_mem_read, o_valid, o_bubble_count
    );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures decode outputs; zeroes controls on stall/flush and counts bubbles.
// Latency: 1 cycle for every field; o_mem_read is a direct slice of the registered MEM control.
// Backpressure: i_enable=0 freezes every register, stall and flush included.
module id_ex_register #(
    parameter int LEN         = 32,
    parameter int NB_ADDR     = 5,
    parameter int NB_CTRL_EX  = 4,
    parameter int NB_CTRL_MEM = 3,
    parameter int NB_CTRL_WB  = 2,
    parameter int MEMREAD_BIT = 1,
    parameter int NB_CNT      = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    id_ex_register_if.slave  bus
);
    typedef struct packed {
        logic [LEN-1:0]     pc_next;
        logic [LEN-1:0]     read_data_1;
        logic [LEN-1:0]     read_data_2;
        logic [LEN-1:0]     sign_ext;
        logic [NB_ADDR-1:0] rs;
        logic [NB_ADDR-1:0] rt;
        logic [NB_ADDR-1:0] rd;
    } data_t;

    typedef struct packed {
        logic [NB_CTRL_EX-1:0]  ex;
        logic [NB_CTRL_MEM-1:0] mem;
        logic [NB_CTRL_WB-1:0]  wb;
    } ctrl_t;

    data_t             data_d, data_q;
    ctrl_t             ctrl_d, ctrl_q;
    logic              valid_q;
    logic [NB_CNT-1:0] cnt_q;
    logic              bubble;
    logic              cnt_sat;

    assign data_d  = '{pc_next: bus.i_pc_next, read_data_1: bus.i_read_data_1,
                       read_data_2: bus.i_read_data_2, sign_ext: bus.i_sign_ext,
                       rs: bus.i_rs, rt: bus.i_rt, rd: bus.i_rd};
    assign ctrl_d  = '{ex: bus.i_ctrl_ex, mem: bus.i_ctrl_mem, wb: bus.i_ctrl_wb};
    // Flush and stall on the same edge are a single bubble.
    assign bubble  = bus.i_flush | bus.i_stall_flag;
    assign cnt_sat = &cnt_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            data_q  <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else if (bus.i_enable) begin
            // Addresses still capture during a bubble so o_rt tracks the stalled instruction.
            data_q <= data_d;
            if (bubble) begin
                ctrl_q  <= '0;
                valid_q <= 1'b0;
                if (!cnt_sat) begin
                    cnt_q <= cnt_q + NB_CNT'(1);
                end
            end else begin
                ctrl_q  <= ctrl_d;
                valid_q <= 1'b1;
            end
        end
    end

    assign bus.o_pc_next      = data_q.pc_next;
    assign bus.o_read_data_1  = data_q.read_data_1;
    assign bus.o_read_data_2  = data_q.read_data_2;
    assign bus.o_sign_ext     = data_q.sign_ext;
    assign bus.o_rs           = data_q.rs;
    assign bus.o_rt           = data_q.rt;
    assign bus.o_rd           = data_q.rd;
    assign bus.o_ctrl_ex      = ctrl_q.ex;
    assign bus.o_ctrl_mem     = ctrl_q.mem;
    assign bus.o_ctrl_wb      = ctrl_q.wb;
    assign bus.o_mem_read     = ctrl_q.mem[MEMREAD_BIT];
    assign bus.o_valid        = valid_q;
    assign bus.o_bubble_count = cnt_q;
endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: directed vectors, queue scoreboard checked by a negedge monitor,
// a small load-use hazard detector in the loop, and a 2-bit-counter instance for saturation.
module tb_id_ex_register;
    logic i_clk = 1'b0;
    logic i_reset;
    always #5 i_clk = ~i_clk;

    id_ex_register_if              bus ();
    id_ex_register_if #(.NB_CNT(2)) sbus ();

    id_ex_register dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    id_ex_register #(.NB_CNT(2)) dut_sat (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (sbus)
    );

    typedef struct packed {
        logic        en, fl, st;
        logic [31:0] pc, rd1, rd2, se;
        logic [4:0]  rs, rt, rd;
        logic [3:0]  ex;
        logic [2:0]  mem;
        logic [1:0]  wb;
    } in_t;

    typedef struct packed {
        logic [31:0] pc, rd1, rd2, se;
        logic [4:0]  rs, rt, rd;
        logic [3:0]  ex;
        logic [2:0]  mem;
        logic [1:0]  wb;
        logic        mem_read, valid;
        logic [15:0] cnt;
    } out_t;

    int         checks = 0;
    int         errors = 0;
    int         stall_seen = 0;
    out_t       model;
    out_t       exp_q[$];
    string      tag_q[$];
    logic [1:0] sat_q[$];
    logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic in_t mk(input logic en, input logic fl, input logic st,
                               input logic [31:0] pc, input logic [31:0] rd1,
                               input logic [31:0] rd2, input logic [31:0] se,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic [3:0] ex, input logic [2:0] mem, input logic [1:0] wb);
        in_t v;
        v = '{en: en, fl: fl, st: st, pc: pc, rd1: rd1, rd2: rd2, se: se,
              rs: rs, rt: rt, rd: rd, ex: ex, mem: mem, wb: wb};
        return v;
    endfunction

    function automatic out_t sample();
        out_t r;
        r = '{pc: bus.o_pc_next, rd1: bus.o_read_data_1, rd2: bus.o_read_data_2,
              se: bus.o_sign_ext, rs: bus.o_rs, rt: bus.o_rt, rd: bus.o_rd,
              ex: bus.o_ctrl_ex, mem: bus.o_ctrl_mem, wb: bus.o_ctrl_wb,
              mem_read: bus.o_mem_read, valid: bus.o_valid, cnt: bus.o_bubble_count};
        return r;
    endfunction

    // Load-use detector standing in for the hazard unit.
    function automatic logic hazard();
        return bus.o_mem_read && (bus.o_rt == bus.i_rs || bus.o_rt == bus.i_rt);
    endfunction

    task automatic drive(input in_t v);
        bus.i_enable      = v.en;
        bus.i_flush       = v.fl;
        bus.i_stall_flag  = v.st;
        bus.i_pc_next     = v.pc;
        bus.i_read_data_1 = v.rd1;
        bus.i_read_data_2 = v.rd2;
        bus.i_sign_ext    = v.se;
        bus.i_rs          = v.rs;
        bus.i_rt          = v.rt;
        bus.i_rd          = v.rd;
        bus.i_ctrl_ex     = v.ex;
        bus.i_ctrl_mem    = v.mem;
        bus.i_ctrl_wb     = v.wb;
    endtask

    task automatic apply_model(input in_t v);
        if (v.en) begin
            model.pc  = v.pc;
            model.rd1 = v.rd1;
            model.rd2 = v.rd2;
            model.se  = v.se;
            model.rs  = v.rs;
            model.rt  = v.rt;
            model.rd  = v.rd;
            if (v.fl || v.st) begin
                model.ex    = 4'd0;
                model.mem   = 3'd0;
                model.wb    = 2'd0;
                model.valid = 1'b0;
                if (model.cnt != 16'hFFFF) model.cnt = model.cnt + 16'd1;
            end else begin
                model.ex    = v.ex;
                model.mem   = v.mem;
                model.wb    = v.wb;
                model.valid = 1'b1;
            end
            model.mem_read = model.mem[1];
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input in_t v, input bit hz, input string tag);
        drive(v);
        if (hz) begin
            #1;
            v.st = hazard();
            bus.i_stall_flag = v.st;
            if (v.st) stall_seen++;
        end
        @(posedge i_clk);
        apply_model(v);
        exp_q.push_back(model);
        tag_q.push_back(tag);
        @(negedge i_clk);
    endtask

    initial begin
        forever begin
            @(negedge i_clk);
            if (exp_q.size() > 0) begin
                out_t  e;
                string t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, sample(), e);
            end
            if (sat_q.size() > 0) begin
                check("sat_count", sbus.o_bubble_count, sat_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model   = '0;
        i_reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sbus.i_enable = 1'b0; sbus.i_flush = 1'b0; sbus.i_stall_flag = 1'b0;
        sbus.i_pc_next = '0; sbus.i_read_data_1 = '0; sbus.i_read_data_2 = '0;
        sbus.i_sign_ext = '0; sbus.i_rs = '0; sbus.i_rt = '0; sbus.i_rd = '0;
        sbus.i_ctrl_ex = '0; sbus.i_ctrl_mem = '0; sbus.i_ctrl_wb = '0;
        #3;
        check("reset_state", sample(), '0);
        check("reset_sat_count", sbus.o_bubble_count, 2'd0);
        @(negedge i_clk);
        i_reset = 1'b0;

        // Reset mid-stream after one bubble and a load.
        step(mk(1, 0, 1, 32'h100, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 4'hF, 3'b111, 2'b11), 0, "pre_stall");
        step(mk(1, 0, 0, 32'h104, 32'h11, 32'h22, 32'h33, 5'd4, 5'd5, 5'd6, 4'h1, 3'b000, 2'b10), 0, "pre_load");
        #1;
        check("pre_rst_rt", bus.o_rt, 5'd5);
        check("pre_rst_cnt", bus.o_bubble_count, 16'd1);
        #1;
        bus.i_enable = 1'b0;
        i_reset = 1'b1;
        #1;
        check("async_rst_rt", bus.o_rt, 5'd0);
        check("async_rst_wb", bus.o_ctrl_wb, 2'b00);
        check("async_rst_valid", bus.o_valid, 1'b0);
        check("async_rst_cnt", bus.o_bubble_count, 16'd0);
        model = '0;
        #1;
        i_reset = 1'b0;

        // lw $7 enters EX.
        step(mk(1, 0, 0, 32'h200, 32'hDEADBEEF, 32'h0, 32'h10, 5'd4, 5'd7, 5'd0, 4'b1001, 3'b010, 2'b11), 0, "capture_lw");
        #1;
        check("cap_rd1", bus.o_read_data_1, 32'hDEADBEEF);
        check("cap_rt", bus.o_rt, 5'd7);
        check("cap_mem_read", bus.o_mem_read, 1'b1);
        check("cap_valid", bus.o_valid, 1'b1);

        // add $9,$7,$8 sits in decode until the hazard clears.
        step(mk(1, 0, 0, 32'h204, 32'h55, 32'h66, 32'h0, 5'd7, 5'd8, 5'd9, 4'b0100, 3'b000, 2'b10), 1, "add_bubble");
        #1;
        check("bubble_ctrl", {bus.o_ctrl_ex, bus.o_ctrl_mem, bus.o_ctrl_wb}, 9'd0);
        check("bubble_valid", bus.o_valid, 1'b0);
        check("bubble_rt", bus.o_rt, 5'd8);
        step(mk(1, 0, 0, 32'h204, 32'h55, 32'h66, 32'h0, 5'd7, 5'd8, 5'd9, 4'b0100, 3'b000, 2'b10), 1, "add_capture");
        #1;
        check("add_valid", bus.o_valid, 1'b1);
        check("add_wb", bus.o_ctrl_wb, 2'b10);
        check("stall_cycles", stall_seen, 1);
        check("loaduse_cnt", bus.o_bubble_count, 16'd1);

        // Coincident flush and stall: one bubble.
        step(mk(1, 1, 1, 32'h300, 32'hA, 32'hB, 32'hC, 5'd1, 5'd3, 5'd2, 4'hF, 3'b111, 2'b11), 0, "flush_stall");
        #1;
        check("fs_ctrl", {bus.o_ctrl_ex, bus.o_ctrl_mem, bus.o_ctrl_wb}, 9'd0);
        check("fs_rt", bus.o_rt, 5'd3);
        check("fs_cnt", bus.o_bubble_count, 16'd2);

        step(mk(1, 1, 0, 32'h304, 32'hD, 32'hE, 32'hF, 5'd2, 5'd4, 5'd6, 4'h3, 3'b100, 2'b01), 0, "flush_only");
        #1;
        check("fl_cnt", bus.o_bubble_count, 16'd3);
        step(mk(1, 0, 0, 32'h308, 32'h12345678, 32'h9, 32'h8, 5'd10, 5'd11, 5'd12, 4'h2, 3'b001, 2'b01), 0, "capture_2");
        #1;
        check("cap2_cnt", bus.o_bubble_count, 16'd3);

        // Hold: stall and inputs change, nothing moves.
        for (int i = 0; i < 3; i++) begin
            step(mk(0, 0, 1, 32'h400 + i, 32'hFFFF0000 + i, 32'h1 + i, 32'h2 + i,
                    5'd20, 5'(21 + i), 5'd22, 4'hF, 3'b111, 2'b11), 0, "hold");
            #1;
            check("hold_rd1", bus.o_read_data_1, 32'h12345678);
            check("hold_cnt", bus.o_bubble_count, 16'd3);
        end
        check("hold_valid", bus.o_valid, 1'b1);

        // Saturation on the 2-bit counter instance.
        sbus.i_enable = 1'b1;
        sbus.i_stall_flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk);
            sat_q.push_back(sat_exp[i]);
            @(negedge i_clk);
        end
        sbus.i_enable = 1'b0;
        sbus.i_stall_flag = 1'b0;

        @(negedge i_clk);
        #1;
        check("queues_drained", exp_q.size() + sat_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
